wei_wr_idxcnt: RTL and testbench

// - Write-side index counter for the weight SRAM. It is the counterpart of the weight read index counter.
// - Accepts a valid/ready stream of weight elements.
// - Walks the same W / tiling-K index space: index = w_idx + til_k_idx.
// - Packs elements into SRAM words of 2**WOFS_W lanes.
// - Issues masked word writes: addr = idx[IDX_W-1:WOFS_W], lane = idx[WOFS_W-1:0].

---
 rtl/wei_wr_pkg.sv | 12 +
 rtl/cnt_generic.sv | 47 ++++
 rtl/wei_wr_idxcnt.sv | 189 ++++++++++++++++++
 tb/tb_wei_wr_idxcnt.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wei_wr_pkg.sv
// wei_wr_pkg: shared types and constants for the weight SRAM write index counter.
//   wei_wr_state_e : write-side FSM state encoding
//   WOFS_W_DFLT    : default word offset width (lanes per SRAM word = 2**WOFS_W)
//   LANES          : lanes per SRAM word at the default offset width
package wei_wr_pkg;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} wei_wr_state_e;

  localparam int WOFS_W_DFLT = 3;
  localparam int LANES       = 2 ** WOFS_W_DFLT;

endpackage

// File: rtl/cnt_generic.sv
// cnt_generic: stepped wrap-around counter.
//   Counts 0, step, 2*step, ... and wraps to 0 on an advance once cnt+step
//   reaches the limit. A limit of 0 is treated as 1.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clear       : synchronous clear to 0 (beats i_adv)
//   i_adv         : advance by one step
//   i_lim, i_step : limit and step, sampled live
//   o_cnt         : current count
//   o_nxt         : value the count takes on the next advance
//   o_ov          : cnt+step >= limit (the next advance wraps)
module cnt_generic #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clear,
  input  logic         i_adv,
  input  logic [W-1:0] i_lim,
  input  logic [W-1:0] i_step,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt,
  output logic         o_ov
);

  logic [W-1:0] cnt_q;
  logic [W:0]   sum;
  logic [W:0]   lim_e;

  // One extra bit so cnt+step cannot wrap before it is compared.
  assign sum   = {1'b0, cnt_q} + {1'b0, i_step};
  assign lim_e = (i_lim == '0) ? {{W{1'b0}}, 1'b1} : {1'b0, i_lim};
  assign o_ov  = (sum >= lim_e);
  assign o_nxt = o_ov ? '0 : sum[W-1:0];
  assign o_cnt = cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_adv) begin
      cnt_q <= o_nxt;
    end
  end

endmodule

// File: rtl/wei_wr_idxcnt.sv
// wei_wr_idxcnt: write-side index counter for the weight SRAM.
//   Accepts a valid/ready stream of weight elements, walks the W / tiling-K
//   index space (index = w_idx + til_k_idx) and issues masked word writes at
//   addr = idx[IDX_W-1:WOFS_W], lane = idx[WOFS_W-1:0].
// Build option:
//   WEI_WR_PACK_EN defined   : elements are packed; one write per word-address
//                              change or at the last position.
//   WEI_WR_PACK_EN undefined : every accepted element is written on its own
//                              (one-hot mask, one element per 2 cycles).
// Ports:
//   i_clk, i_rstn              : clock, asynchronous active-low reset
//   i_start                    : start a fill (taken in IDLE or DONE)
//   i_cnt_clear                : synchronous clear, highest priority
//   i_wlim, i_wstep            : W counter limit / step
//   i_til_klim, i_til_kstep    : tiling-K counter limit / step
//   i_data, i_valid, o_ready   : element stream
//   i_sram_stall               : SRAM cannot take the write this cycle
//   o_sram_we/addr/wdata/wmask : masked SRAM word write
//   o_busy                     : FILL or FLUSH
//   o_done                     : all positions written (held until restart)
//
// state | meaning
// IDLE  | reset / cleared, waiting for i_start
// FILL  | accepting elements into the packing buffer
// FLUSH | presenting the buffered word to the SRAM until it is taken
// DONE  | all positions written, waiting for i_start
module wei_wr_idxcnt
  import wei_wr_pkg::*;
#(
  parameter int IDX_W  = 11,
  parameter int ADRB_W = 8,
  parameter int WOFS_W = WOFS_W_DFLT,
  parameter int ELEM_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_start,
  input  logic                          i_cnt_clear,
  input  logic [IDX_W-1:0]              i_wlim,
  input  logic [IDX_W-1:0]              i_wstep,
  input  logic [IDX_W-1:0]              i_til_klim,
  input  logic [IDX_W-1:0]              i_til_kstep,
  input  logic [ELEM_W-1:0]             i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_sram_stall,
  output logic                          o_sram_we,
  output logic [ADRB_W-1:0]             o_sram_addr,
  output logic [ELEM_W*(2**WOFS_W)-1:0] o_sram_wdata,
  output logic [(2**WOFS_W)-1:0]        o_sram_wmask,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int NLANES = 2 ** WOFS_W;

  wei_wr_state_e state_q;

  logic                     ready_q;
  logic                     we_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     last_q;
  logic [ADRB_W-1:0]        addr_q;
  logic [ELEM_W*NLANES-1:0] wbuf_q;
  logic [NLANES-1:0]        mask_q;

  logic [IDX_W-1:0]  w_cnt, w_nxt, k_cnt, k_nxt, idx;
  logic              w_ov, k_ov, last, beat, start_take, cnt_clr, close_word;
  logic [WOFS_W-1:0] lane;

  // ready_q is only ever set in FILL, so it alone qualifies a beat.
  assign beat       = ready_q & i_valid;
  assign start_take = i_start & ((state_q == IDLE) | (state_q == DONE));
  assign cnt_clr    = i_cnt_clear | start_take;

  cnt_generic #(.W(IDX_W)) u_wcnt (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clear (cnt_clr),
    .i_adv   (beat),
    .i_lim   (i_wlim),
    .i_step  (i_wstep),
    .o_cnt   (w_cnt),
    .o_nxt   (w_nxt),
    .o_ov    (w_ov)
  );

  cnt_generic #(.W(IDX_W)) u_kcnt (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clear (cnt_clr),
    .i_adv   (beat & w_ov),
    .i_lim   (i_til_klim),
    .i_step  (i_til_kstep),
    .o_cnt   (k_cnt),
    .o_nxt   (k_nxt),
    .o_ov    (k_ov)
  );

  assign idx  = w_cnt + k_cnt;
  assign lane = idx[WOFS_W-1:0];
  assign last = w_ov & k_ov;

`ifdef WEI_WR_PACK_EN
  // Index of the following element; a word closes when it leaves this word.
  logic [IDX_W-1:0] idx_nxt;
  assign idx_nxt    = w_nxt + (w_ov ? k_nxt : k_cnt);
  assign close_word = last | ((idx_nxt >> WOFS_W) != (idx >> WOFS_W));
`else
  logic unused_nxt;
  assign unused_nxt = ^{w_nxt, k_nxt};
  assign close_word = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      mask_q  <= '0;
    end else if (i_cnt_clear) begin
      // Drops any partial word without writing it.
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            state_q <= FILL;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        FILL: begin
          if (beat) begin
            wbuf_q[int'(lane)*ELEM_W +: ELEM_W] <= i_data;
            mask_q[lane] <= 1'b1;
            addr_q       <= ADRB_W'(idx >> WOFS_W);
            last_q       <= last;
            if (close_word) begin
              state_q <= FLUSH;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!i_sram_stall) begin
            we_q   <= 1'b0;
            wbuf_q <= '0;
            mask_q <= '0;
            if (last_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= FILL;
              ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_sram_we    = we_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wbuf_q;
  assign o_sram_wmask = mask_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_wei_wr_idxcnt.sv
module tb_wei_wr_idxcnt;
  import wei_wr_pkg::*;

  localparam int IDX_W  = 11;
  localparam int ADRB_W = 8;
  localparam int WOFS_W = 3;
  localparam int ELEM_W = 8;
  localparam int WD     = ELEM_W * LANES;
`ifdef WEI_WR_PACK_EN
  localparam bit PACK = 1'b1;
`else
  localparam bit PACK = 1'b0;
`endif

  logic              i_clk, i_rstn, i_start, i_cnt_clear;
  logic [IDX_W-1:0]  i_wlim, i_wstep, i_til_klim, i_til_kstep;
  logic [ELEM_W-1:0] i_data;
  logic              i_valid, o_ready, i_sram_stall, o_sram_we, o_busy, o_done;
  logic [ADRB_W-1:0] o_sram_addr;
  logic [WD-1:0]     o_sram_wdata;
  logic [LANES-1:0]  o_sram_wmask;

  wei_wr_idxcnt #(.IDX_W(IDX_W), .ADRB_W(ADRB_W), .WOFS_W(WOFS_W), .ELEM_W(ELEM_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_cnt_clear(i_cnt_clear),
    .i_wlim(i_wlim), .i_wstep(i_wstep), .i_til_klim(i_til_klim), .i_til_kstep(i_til_kstep),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .i_sram_stall(i_sram_stall),
    .o_sram_we(o_sram_we), .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
    .o_sram_wmask(o_sram_wmask), .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ADRB_W-1:0] addr;
    logic [LANES-1:0]  mask;
    logic [WD-1:0]     wdata;
  } wr_t;

  wr_t               exp_q[$];
  int                idxl[$];
  logic [ELEM_W-1:0] dat[$];
  int checks   = 0;
  int failures = 0;

  bit stall_rand = 1'b0;
  bit stall_hold = 1'b0;

  task automatic check(input string nm, input logic [WD-1:0] act, input logic [WD-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: W positions are 0, s, 2s, ... for ceil(lim/s) entries
  // (lim 0 counts as 1); K is the outer loop; index wraps mod 2**IDX_W.
  task automatic gen_idx(input int wl, input int ws, input int kl, input int ks);
    int lw, lk, nw, nk;
    lw = (wl == 0) ? 1 : wl;
    lk = (kl == 0) ? 1 : kl;
    nw = (lw + ws - 1) / ws;
    nk = (lk + ks - 1) / ks;
    idxl.delete();
    for (int j = 0; j < nk; j++)
      for (int i = 0; i < nw; i++)
        idxl.push_back((i * ws + j * ks) % (1 << IDX_W));
  endtask

  // Expected writes for the first 'sent' beats; a word is written once the
  // following element falls in another word or the walk ends (always, when
  // packing is disabled). A word left open by a clear is never written.
  task automatic model_push(input int sent);
    wr_t cur;
    cur = '0;
    for (int j = 0; j < sent; j++) begin
      int ix, ln;
      ix = idxl[j];
      ln = ix % LANES;
      cur.addr = ADRB_W'(ix / LANES);
      cur.mask[ln] = 1'b1;
      cur.wdata[ln*ELEM_W +: ELEM_W] = dat[j];
      if (!PACK || j == idxl.size() - 1 || (idxl[j+1] / LANES) != (ix / LANES)) begin
        exp_q.push_back(cur);
        cur = '0;
      end
    end
  endtask

  // Stall driver
  int hold_left = 0;
  bit held = 1'b0;
  always begin
    @(posedge i_clk); #1;
    if (stall_hold) begin
      if (o_sram_we && hold_left == 0 && !held) begin
        hold_left = 3;
        held = 1'b1;
      end
      if (hold_left > 0) begin
        i_sram_stall = 1'b1;
        hold_left--;
      end else begin
        i_sram_stall = 1'b0;
      end
      if (!o_sram_we) held = 1'b0;
    end else if (stall_rand) begin
      i_sram_stall = ($urandom_range(0, 2) == 0);
    end else begin
      i_sram_stall = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every completed write and checks that a
  // stalled write is held unchanged.
  bit  st_prev = 1'b0;
  wr_t st_cap;
  always @(negedge i_clk) begin
    if (i_rstn) begin
      if (st_prev) begin
        check("stall_we",    {63'd0, o_sram_we}, 64'd1);
        check("stall_ready", {63'd0, o_ready},   64'd0);
        check("stall_addr",  WD'(o_sram_addr),   WD'(st_cap.addr));
        check("stall_mask",  WD'(o_sram_wmask),  WD'(st_cap.mask));
        check("stall_wdata", o_sram_wdata,       st_cap.wdata);
      end
      st_prev = o_sram_we && i_sram_stall;
      st_cap  = '{addr: o_sram_addr, mask: o_sram_wmask, wdata: o_sram_wdata};
      if (o_sram_we && !i_sram_stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", WD'(o_sram_addr), '1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr",  WD'(o_sram_addr),  WD'(e.addr));
          check("wr_mask",  WD'(o_sram_wmask), WD'(e.mask));
          check("wr_wdata", o_sram_wdata,      e.wdata);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string nm);
    check({nm, "_we"},    {63'd0, o_sram_we}, 64'd0);
    check({nm, "_ready"}, {63'd0, o_ready},   64'd0);
    check({nm, "_busy"},  {63'd0, o_busy},    64'd0);
    check({nm, "_done"},  {63'd0, o_done},    64'd0);
    check({nm, "_addr"},  WD'(o_sram_addr),   '0);
    check({nm, "_mask"},  WD'(o_sram_wmask),  '0);
    check({nm, "_wdata"}, o_sram_wdata,       '0);
  endtask

  // Called at posedge+1. stop_after < 0 runs the whole walk; otherwise the
  // fill is cleared after that many beats.
  task automatic run_fill(input string nm, input int wl, input int ws, input int kl, input int ks,
                          input bit drops, input int stop_after, input bit fixed,
                          input logic [ELEM_W-1:0] base);
    int sent, i, guard;
    logic rdy;
    gen_idx(wl, ws, kl, ks);
    dat.delete();
    for (int j = 0; j < idxl.size(); j++)
      dat.push_back(fixed ? ELEM_W'(base + j) : ELEM_W'($urandom));
    sent = (stop_after < 0) ? idxl.size() : stop_after;
    model_push(sent);
    i_wlim = IDX_W'(wl); i_wstep = IDX_W'(ws);
    i_til_klim = IDX_W'(kl); i_til_kstep = IDX_W'(ks);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check({nm, "_start_busy"}, {63'd0, o_busy},  64'd1);
    check({nm, "_start_done"}, {63'd0, o_done},  64'd0);
    i = 0; guard = 0;
    while (i < sent) begin
      i_data  = dat[i];
      i_valid = drops ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge i_clk); rdy = o_ready;
      @(posedge i_clk); #1;
      if (i_valid && rdy) i++;
      guard++;
      if (guard > 5000) begin
        check({nm, "_beat_timeout"}, WD'(i), WD'(sent));
        break;
      end
    end
    i_valid = 1'b0;
    if (stop_after < 0) begin
      guard = 0;
      while (!o_done && guard < 200) begin
        @(posedge i_clk); #1;
        guard++;
      end
      check({nm, "_done"}, {63'd0, o_done}, 64'd1);
      repeat (3) @(posedge i_clk);
      #1;
      check({nm, "_done_held"}, {63'd0, o_done},  64'd1);
      check({nm, "_busy_end"},  {63'd0, o_busy},  64'd0);
      check({nm, "_ready_end"}, {63'd0, o_ready}, 64'd0);
      check({nm, "_sb_empty"},  WD'(exp_q.size()), '0);
    end else begin
      guard = 0;
      while (!o_ready && guard < 50) begin
        @(posedge i_clk); #1;
        guard++;
      end
      i_cnt_clear = 1'b1;
      @(posedge i_clk); #1;
      i_cnt_clear = 1'b0;
      check_idle_outputs({nm, "_clr"});
      check({nm, "_clr_sb_empty"}, WD'(exp_q.size()), '0);
      // Clear wins over a simultaneous start.
      i_start = 1'b1; i_cnt_clear = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0; i_cnt_clear = 1'b0;
      check({nm, "_clr_beats_start"}, {63'd0, o_busy}, 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 1'b0; i_start = 1'b0; i_cnt_clear = 1'b0;
    i_wlim = '0; i_wstep = '0; i_til_klim = '0; i_til_kstep = '0;
    i_data = '0; i_valid = 1'b0; i_sram_stall = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_idle_outputs("reset_async");
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    check_idle_outputs("reset");

    run_fill("pack",   8, 1, 1, 1, 1'b0, -1, 1'b1, 8'h01);
    run_fill("sparse", 8, 2, 1, 1, 1'b0, -1, 1'b1, 8'hA0);
    run_fill("tiling", 4, 1, 24, 8, 1'b0, -1, 1'b0, 8'h00);

    stall_rand = 1'b1;
    run_fill("gaps", 4, 1, 24, 8, 1'b1, -1, 1'b0, 8'h00);
    stall_rand = 1'b0;

    stall_hold = 1'b1;
    run_fill("stall3", 8, 1, 1, 1, 1'b0, -1, 1'b1, 8'h01);
    stall_hold = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    run_fill("clear",  8, 1, 1, 1, 1'b0, 5, 1'b1, 8'h01);
    run_fill("refill", 8, 1, 1, 1, 1'b0, -1, 1'b1, 8'h11);

    stall_rand = 1'b1;
    for (int t = 0; t < 5; t++) begin
      run_fill("rand", int'($urandom_range(0, 20)), int'($urandom_range(1, 4)),
               int'($urandom_range(0, 40)), int'($urandom_range(1, 12)),
               1'b1, -1, 1'b0, 8'h00);
    end
    stall_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
